mil_ring_bank: RTL and testbench

Parametrised N-ring FIFO bank sharing one single-port memory, the next-generation ring-buffer store behind the MIL/SPI bridges. It generalises the fixed four-ring memory block to NUM_RINGS rings of RING_DEPTH words, placed contiguously from BASE_ADDR. It adds round-robin arbitration, per-ring clear and per-ring fill counts. It sits between the SPI/MIL channel blocks (push/pop clients) and the memory wrapper.

---
 rtl/mil_ring_bank_pkg.sv | 13 +
 rtl/mil_ring_bank_arbiter.sv | 28 ++
 rtl/mil_ring_bank.sv | 163 ++++++++++++++++
 tb/tb_mil_ring_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mil_ring_bank_pkg.sv
// Shared definitions for the ring-buffer store: default memory read latency
// and the encoding of the single memory operation issued per cycle.
package mil_ring_bank_pkg;

  localparam int RD_LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } mem_op_e;

endpackage

// File: rtl/mil_ring_bank_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester found when
// searching upward from ptr, wrapping modulo N.
module round_robin_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mil_ring_bank.sv
// NUM_RINGS FIFO rings sharing one single-port memory: round-robin grant of
// one push or pop per cycle, per-ring clear, fill counts and a read-tag pipeline.
module mil_ring_bank
  import mil_ring_bank_pkg::*;
#(
  parameter int NUM_RINGS  = 4,
  parameter int RING_DEPTH = 64,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int BASE_ADDR  = 0,
  parameter int RD_LAT     = RD_LAT_DEFAULT
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [NUM_RINGS-1:0]                            push_req,
  input  logic [NUM_RINGS*DATA_W-1:0]                     push_data,
  output logic [NUM_RINGS-1:0]                            push_ack,
  input  logic [NUM_RINGS-1:0]                            pop_req,
  output logic [NUM_RINGS-1:0]                            pop_ack,
  output logic [NUM_RINGS-1:0]                            pop_valid,
  output logic [DATA_W-1:0]                               pop_data,
  input  logic [NUM_RINGS-1:0]                            clear,
  output logic [NUM_RINGS-1:0]                            empty,
  output logic [NUM_RINGS-1:0]                            full,
  output logic [NUM_RINGS*($clog2(RING_DEPTH)+1)-1:0]     count,
  output logic [ADDR_W-1:0]                               mem_addr,
  output logic [DATA_W-1:0]                               mem_wr_data,
  output logic                                            mem_wr_en,
  output logic                                            mem_rd_en,
  input  logic [DATA_W-1:0]                               mem_rd_data
);

  localparam int PW = $clog2(RING_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (NUM_RINGS > 1) ? $clog2(NUM_RINGS) : 1;

  logic [PW-1:0]        wr_ptr   [NUM_RINGS];
  logic [PW-1:0]        rd_ptr   [NUM_RINGS];
  logic [CW-1:0]        cnt      [NUM_RINGS];
  logic [NUM_RINGS-1:0] pick_pop;
  logic [IW-1:0]        rr_ptr;

  logic [RD_LAT:0]      tag_vld_p;
  logic [IW-1:0]        tag_ring_p [RD_LAT+1];

  logic [NUM_RINGS-1:0] in_flight, push_elig, pop_elig, ring_req, gnt;
  logic                 gnt_any, do_push, do_pop;
  logic [IW-1:0]        gnt_idx;
  logic [PW-1:0]        sel_ptr;
  logic [ADDR_W-1:0]    op_addr;
  mem_op_e              op_sel;

  always_comb begin
    empty     = '0;
    full      = '0;
    count     = '0;
    in_flight = '0;
    for (int i = 0; i < NUM_RINGS; i++) begin
      empty[i]            = (cnt[i] == '0);
      full[i]             = (cnt[i] == CW'(RING_DEPTH));
      count[i*CW +: CW]   = cnt[i];
      for (int s = 0; s <= RD_LAT; s++)
        if (tag_vld_p[s] && tag_ring_p[s] == IW'(i)) in_flight[i] = 1'b1;
    end
    push_elig = push_req & ~full & ~clear;
    pop_elig  = pop_req & ~empty & ~clear & ~in_flight;
    ring_req  = (push_elig | pop_elig) & {NUM_RINGS{~rst}};
  end

  round_robin_arbiter #(.N(NUM_RINGS)) u_arb (
    .req   (ring_req),
    .ptr   (rr_ptr),
    .grant (gnt)
  );

  // A tie inside the granted ring is settled by that ring's toggle.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_RINGS; i++)
      if (gnt[i]) gnt_idx = IW'(i);
    gnt_any  = |gnt;
    do_pop   = gnt_any && pop_elig[gnt_idx] &&
               (!push_elig[gnt_idx] || pick_pop[gnt_idx]);
    do_push  = gnt_any && push_elig[gnt_idx] && !do_pop;
    push_ack = do_push ? gnt : '0;
    pop_ack  = do_pop  ? gnt : '0;
    sel_ptr  = do_pop ? rd_ptr[gnt_idx] : wr_ptr[gnt_idx];
    op_sel   = do_push ? WRITE : (do_pop ? READ : IDLE);
    op_addr  = '0;
    if (gnt_any)
      op_addr = ADDR_W'(BASE_ADDR) + (ADDR_W'(gnt_idx) << PW) + ADDR_W'(sel_ptr);
  end

  // Stage p0: ring state update and registered memory command.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RINGS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      pick_pop    <= '0;
      rr_ptr      <= '0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      for (int i = 0; i < NUM_RINGS; i++) begin
        if (clear[i]) begin
          wr_ptr[i]   <= '0;
          rd_ptr[i]   <= '0;
          cnt[i]      <= '0;
          pick_pop[i] <= 1'b0;
        end else begin
          if (push_ack[i]) begin
            wr_ptr[i] <= wr_ptr[i] + 1'b1;
            cnt[i]    <= cnt[i] + 1'b1;
          end
          if (pop_ack[i]) begin
            rd_ptr[i] <= rd_ptr[i] + 1'b1;
            cnt[i]    <= cnt[i] - 1'b1;
          end
          if ((push_ack[i] || pop_ack[i]) && push_elig[i] && pop_elig[i])
            pick_pop[i] <= ~pick_pop[i];
        end
      end
      if (gnt_any)
        rr_ptr <= (gnt_idx == IW'(NUM_RINGS - 1)) ? '0 : gnt_idx + 1'b1;
      mem_wr_en   <= (op_sel == WRITE);
      mem_rd_en   <= (op_sel == READ);
      mem_addr    <= op_addr;
      mem_wr_data <= do_push ? push_data[int'(gnt_idx)*DATA_W +: DATA_W] : '0;
    end
  end

  // Stages p0..pRD_LAT: read tags; a clear of the owning ring kills its tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_p <= '0;
    end else begin
      tag_vld_p[0] <= do_pop;
      for (int s = 1; s <= RD_LAT; s++)
        tag_vld_p[s] <= tag_vld_p[s-1] && !clear[tag_ring_p[s-1]];
    end
  end

  always_ff @(posedge clk) begin
    tag_ring_p[0] <= gnt_idx;
    for (int s = 1; s <= RD_LAT; s++)
      tag_ring_p[s] <= tag_ring_p[s-1];
  end

  always_comb begin
    pop_valid = '0;
    pop_data  = '0;
    if (tag_vld_p[RD_LAT]) begin
      pop_valid[tag_ring_p[RD_LAT]] = 1'b1;
      pop_data                      = mem_rd_data;
    end
  end

endmodule

// File: tb/tb_mil_ring_bank.sv
// Directed bench for mil_ring_bank (4 rings x 64 words, read latency 2) with a
// behavioural single-port memory behind it.
module tb_mil_ring_bank;

  localparam int N  = 4;
  localparam int D  = 64;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  push_req, push_ack, pop_req, pop_ack, pop_valid, clear, empty, full;
  logic [N*DW-1:0] push_data;
  logic [DW-1:0] pop_data, mem_wr_data, mem_rd_data;
  logic [N*CW-1:0] count;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en, mem_rd_en;

  int errors = 0;
  int checks = 0;
  int acks;

  always #5 clk = ~clk;

  mil_ring_bank #(
    .NUM_RINGS(N), .RING_DEPTH(D), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(0), .RD_LAT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .push_req(push_req), .push_data(push_data), .push_ack(push_ack),
    .pop_req(pop_req), .pop_ack(pop_ack), .pop_valid(pop_valid), .pop_data(pop_data),
    .clear(clear), .empty(empty), .full(full), .count(count),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data)
  );

  // Memory with two cycles from mem_rd_en to mem_rd_data.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_d1, rd_d2;
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[7:0]] <= mem_wr_data;
    rd_d1 <= mem_rd_en ? mem[mem_addr[7:0]] : '0;
    rd_d2 <= rd_d1;
  end
  assign mem_rd_data = rd_d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pd(input int i, input logic [DW-1:0] v);
    push_data[i*DW +: DW] = v;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int i);
    return count[i*CW +: CW];
  endfunction

  logic [AW-1:0] rr_addr [4] = '{16'h0000, 16'h0042, 16'h0080, 16'h00C0};

  initial begin
    rst = 1'b1; push_req = '0; pop_req = '0; clear = '0; push_data = '0;
    nxt(); nxt();
    push_req = 4'hF;
    #1;
    chk("rst_push_ack", push_ack, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_pop_data", pop_data, 0);
    chk("rst_empty", empty, 4'hF);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_mem_en", {mem_wr_en, mem_rd_en}, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // Ring 1: two pushes then two pops.
    nxt(); rst = 1'b0; push_req = 4'b0010; set_pd(1, 16'h0002); #1;
    chk("r1_push0_ack", push_ack, 4'b0010);
    nxt(); set_pd(1, 16'hAB45); #1;
    chk("r1_wr0_en", mem_wr_en, 1);
    chk("r1_wr0_addr", mem_addr, 16'h0040);
    chk("r1_wr0_data", mem_wr_data, 16'h0002);
    chk("r1_count1", cnt_of(1), 1);
    chk("r1_push1_ack", push_ack, 4'b0010);
    nxt(); push_req = '0; #1;
    chk("r1_wr1_addr", mem_addr, 16'h0041);
    chk("r1_wr1_data", mem_wr_data, 16'hAB45);
    chk("r1_empty", empty, 4'b1101);
    nxt(); pop_req = 4'b0010; #1;
    chk("r1_pop0_ack", pop_ack, 4'b0010);
    nxt(); #1;
    chk("r1_rd0_en", mem_rd_en, 1);
    chk("r1_rd0_addr", mem_addr, 16'h0040);
    chk("r1_inflight_block", pop_ack, 0);
    nxt(); #1;
    chk("r1_early_valid", pop_valid, 0);
    nxt(); #1;
    chk("r1_pop0_valid", pop_valid, 4'b0010);
    chk("r1_pop0_data", pop_data, 16'h0002);
    chk("r1_still_blocked", pop_ack, 0);
    nxt(); #1;
    chk("r1_pop1_ack", pop_ack, 4'b0010);
    nxt(); pop_req = '0; #1;
    chk("r1_rd1_addr", mem_addr, 16'h0041);
    chk("r1_count0", cnt_of(1), 0);
    chk("r1_empty_all", empty, 4'hF);
    nxt(); #1;
    chk("r1_gap_data", pop_data, 0);
    nxt(); #1;
    chk("r1_pop1_valid", pop_valid, 4'b0010);
    chk("r1_pop1_data", pop_data, 16'hAB45);

    // Ring 3: fill to 64, stall, pop one, wrap-around write.
    acks = 0;
    for (int k = 0; k < 64; k++) begin
      nxt(); push_req = 4'b1000; set_pd(3, 16'h3000 + 16'(k)); #1;
      if (push_ack == 4'b1000) acks++;
    end
    chk("r3_fill_acks", acks, 64);
    nxt(); set_pd(3, 16'h3040); #1;
    chk("r3_full_stall", push_ack, 0);
    chk("r3_full", full, 4'b1000);
    chk("r3_count64", cnt_of(3), 64);
    chk("r3_last_addr", mem_addr, 16'h00FF);
    nxt(); pop_req = 4'b1000; #1;
    chk("r3_pop_ack", pop_ack, 4'b1000);
    chk("r3_push_still", push_ack, 0);
    nxt(); pop_req = '0; #1;
    chk("r3_push65_ack", push_ack, 4'b1000);
    chk("r3_count63", cnt_of(3), 63);
    chk("r3_rd_addr", mem_addr, 16'h00C0);
    nxt(); push_req = '0; #1;
    chk("r3_wrap_en", mem_wr_en, 1);
    chk("r3_wrap_addr", mem_addr, 16'h00C0);
    chk("r3_wrap_data", mem_wr_data, 16'h3040);
    nxt(); #1;
    chk("r3_pop_data", pop_data, 16'h3000);
    chk("r3_pop_valid", pop_valid, 4'b1000);
    nxt(); clear = 4'b1000; #1;
    nxt(); clear = '0; #1;
    chk("r3_clear_count", cnt_of(3), 0);
    chk("r3_clear_empty", empty, 4'hF);

    // All rings pushing: grants rotate 0,1,2,3,0.
    push_data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    for (int k = 0; k < 5; k++) begin
      nxt(); push_req = 4'hF; #1;
      chk("rr_ack", push_ack, 32'(1) << (k % 4));
      if (k > 0) begin
        chk("rr_wr_en", mem_wr_en, 1);
        chk("rr_addr", mem_addr, rr_addr[k-1]);
      end
    end
    nxt(); push_req = '0; #1;
    chk("rr_addr_last", mem_addr, 16'h0001);

    // Ring 0 to count 5, then push and pop held together.
    for (int k = 0; k < 3; k++) begin
      nxt(); push_req = 4'b0001; set_pd(0, 16'h1100 + 16'(k)); #1;
    end
    nxt(); push_req = 4'b0001; pop_req = 4'b0001; #1;
    chk("tie_count5", cnt_of(0), 5);
    chk("tie1_push", push_ack, 4'b0001);
    chk("tie1_pop", pop_ack, 0);
    nxt(); #1;
    chk("tie2_pop", pop_ack, 4'b0001);
    chk("tie2_push", push_ack, 0);
    chk("tie_count6", cnt_of(0), 6);
    chk("tie_wr_addr", mem_addr, 16'h0005);
    nxt(); push_req = '0; pop_req = '0; #1;
    chk("tie_count_back5", cnt_of(0), 5);
    chk("tie_rd_addr", mem_addr, 16'h0000);
    chk("tie_rd_en", mem_rd_en, 1);
    nxt(); nxt(); #1;
    chk("tie_pop_valid", pop_valid, 4'b0001);
    chk("tie_pop_data", pop_data, 16'h1000);

    // Ring 2: pop then clear while the read is in flight.
    nxt(); pop_req = 4'b0100; #1;
    chk("clr_pop_ack", pop_ack, 4'b0100);
    nxt(); pop_req = '0; clear = 4'b0100; #1;
    chk("clr_rd_addr", mem_addr, 16'h0080);
    nxt(); clear = '0; #1;
    chk("clr_empty2", empty[2], 1);
    chk("clr_count2", cnt_of(2), 0);
    chk("clr_no_valid_a", pop_valid, 0);
    nxt(); #1;
    chk("clr_no_valid_b", pop_valid, 0);
    push_req = 4'b0100; set_pd(2, 16'h2222); #1;
    chk("clr_push_ack", push_ack, 4'b0100);
    nxt(); push_req = '0; #1;
    chk("clr_push_addr", mem_addr, 16'h0080);

    // Reset with a read in flight.
    nxt(); pop_req = 4'b0100; #1;
    chk("mrst_pop_ack", pop_ack, 4'b0100);
    nxt(); pop_req = '0; rst = 1'b1; #1;
    chk("mrst_rd_en", mem_rd_en, 1);
    nxt(); rst = 1'b0; #1;
    chk("mrst_rd_en0", mem_rd_en, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 4'hF);
    chk("mrst_full", full, 0);
    nxt(); #1;
    chk("mrst_no_valid", pop_valid, 0);
    chk("mrst_no_data", pop_data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
